// File: rtl/cast_input_unit_pkg.sv
// Shared constants, types and helpers for the cast router input unit.
package cast_pkg;

    localparam int unsigned VN  = 4;
    localparam int unsigned PN  = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned VIW = $clog2(VN);

    typedef logic [VIW-1:0] vc_idx_t;
    typedef logic [PN-1:0]  port_mask_t;
    typedef logic [DW-1:0]  flit_t;

    // Isolates the lowest set bit of a port mask (zero stays zero).
    function automatic port_mask_t lowest_bit(input port_mask_t m);
        return m & (~m + port_mask_t'(1));
    endfunction

endpackage

// File: rtl/cast_input_unit_if.sv
// Flit, crossbar and routing-config signals of the cast input unit.
interface cast_input_unit_if #(
    parameter int unsigned DEPTH = 4
);
    import cast_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [VN-1:0]          vc_i;
    flit_t                  data_i;
    logic                   valid_i;
    logic                   ready_o;

    flit_t      [VN-1:0]    data_o;
    logic       [VN-1:0]    valid_o;
    port_mask_t [VN-1:0]    req_port;
    port_mask_t [VN-1:0]    ready_i;
    logic [VN-1:0][CW-1:0]  count_o;

    logic                   cfg_we;
    vc_idx_t                cfg_vc;
    port_mask_t             cfg_mask;
    logic                   cfg_ready_o;

    modport slave (
        input  vc_i, data_i, valid_i, ready_i, cfg_we, cfg_vc, cfg_mask,
        output ready_o, data_o, valid_o, req_port, count_o, cfg_ready_o
    );

    modport master (
        output vc_i, data_i, valid_i, ready_i, cfg_we, cfg_vc, cfg_mask,
        input  ready_o, data_o, valid_o, req_port, count_o, cfg_ready_o
    );

endinterface

// File: rtl/cast_fork_tracker.sv
// Per-VC route mask and outstanding-copy tracker for multicast head flits.
// Defining CAST_PARALLEL_FORK_EN requests every outstanding port at once.
module cast_fork_tracker
    import cast_pkg::*;
#(
    parameter port_mask_t ROUTE_INIT = '0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we_i,
    input  port_mask_t cfg_mask_i,
    input  logic       empty_i,
    input  port_mask_t ready_i,
    output port_mask_t req_port_o,
    output logic       valid_o,
    output logic       pop_o,
    output logic       idle_o
);

    port_mask_t route_q, route_d;
    port_mask_t pend_q,  pend_d;
    port_mask_t eff, rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            route_q <= ROUTE_INIT;
            pend_q  <= '0;
        end else begin
            route_q <= route_d;
            pend_q  <= pend_d;
        end
    end

    // A zero route mask silently drops the head flit each cycle.
    always_comb begin
        route_d    = route_q;
        pend_d     = pend_q;
        req_port_o = '0;
        valid_o    = 1'b0;
        pop_o      = 1'b0;
        eff        = (pend_q == '0) ? route_q : pend_q;
        rem        = eff;

        if (!empty_i) begin
            if (route_q == '0) begin
                pop_o = 1'b1;
            end else begin
                valid_o = 1'b1;
`ifdef CAST_PARALLEL_FORK_EN
                req_port_o = eff;
                rem        = eff & ~(eff & ready_i);
                pend_d     = rem;
                pop_o      = (rem == '0);
`else
                req_port_o = lowest_bit(eff);
                if ((req_port_o & ready_i) != '0) begin
                    rem    = eff & ~req_port_o;
                    pend_d = rem;
                    pop_o  = (rem == '0);
                end
`endif
            end
        end

        if (cfg_we_i) route_d = cfg_mask_i;
    end

    assign idle_o = (pend_q == '0);

endmodule

// File: rtl/network_fifo.sv
// Power-of-two circular FIFO; FWFT=1 presents the head word combinationally.
module network_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter bit          FWFT  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [DW-1:0]                wr_data_i,
    input  logic                         rd_en_i,
    output logic [DW-1:0]                rd_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_wr, do_rd;

    // Full/empty come from the registered count only.
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_wr   = wr_en_i & ~full_o;
    assign do_rd   = rd_en_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data_o = mem_q[rd_ptr_q];
        end else begin : g_std
            logic [DW-1:0] rd_data_q;
            always_ff @(posedge clk) begin
                if (rst)        rd_data_q <= '0;
                else if (do_rd) rd_data_q <= mem_q[rd_ptr_q];
            end
            assign rd_data_o = rd_data_q;
        end
    endgenerate

endmodule

// File: rtl/cast_input_unit.sv
// Multicast input port: per-VC FWFT buffering plus head-flit replication
// to a run-time port mask (parallel fork when CAST_PARALLEL_FORK_EN is defined).
module cast_input_unit
    import cast_pkg::*;
#(
    parameter int unsigned            DEPTH      = 4,
    parameter logic [VN-1:0][PN-1:0]  ROUTE_INIT = '0
) (
    input logic              clk,
    input logic              rst,
    cast_input_unit_if.slave bus
);

    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned VSEL = 1 << VIW;

    logic       [VN-1:0]         full, empty, pop, idle, valid, wr_en, cfg_hit;
    flit_t      [VN-1:0]         head;
    port_mask_t [VN-1:0]         req;
    logic       [VN-1:0][CW-1:0] cnt;
    logic       [VSEL-1:0]       cfg_ok;
    logic                        onehot_c, in_ready_c, wr_accept_c, cfg_ready_c;

    // Input side sees only registered fullness, so no path from ready_i.
    always_comb begin
        onehot_c    = (bus.vc_i != '0) && ((bus.vc_i & (bus.vc_i - VN'(1))) == '0);
        in_ready_c  = onehot_c & ~(|(bus.vc_i & full));
        wr_accept_c = bus.valid_i & in_ready_c;
        wr_en       = {VN{wr_accept_c}} & bus.vc_i;
    end

    // Config index space may exceed VN; unused slots never accept.
    generate
        for (genvar i = 0; i < VSEL; i++) begin : g_cfg_ok
            if (i < VN) begin : g_in
                assign cfg_ok[i] = empty[i] & idle[i];
            end else begin : g_out
                assign cfg_ok[i] = 1'b0;
            end
        end
    endgenerate

    assign cfg_ready_c = cfg_ok[bus.cfg_vc];

    generate
        for (genvar v = 0; v < VN; v++) begin : g_vc
            assign cfg_hit[v] = bus.cfg_we & cfg_ready_c & (bus.cfg_vc == vc_idx_t'(v));

            network_fifo #(
                .DW    (DW),
                .DEPTH (DEPTH),
                .FWFT  (1'b1)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .wr_en_i   (wr_en[v]),
                .wr_data_i (bus.data_i),
                .rd_en_i   (pop[v]),
                .rd_data_o (head[v]),
                .full_o    (full[v]),
                .empty_o   (empty[v]),
                .count_o   (cnt[v])
            );

            cast_fork_tracker #(
                .ROUTE_INIT (ROUTE_INIT[v])
            ) u_tracker (
                .clk        (clk),
                .rst        (rst),
                .cfg_we_i   (cfg_hit[v]),
                .cfg_mask_i (bus.cfg_mask),
                .empty_i    (empty[v]),
                .ready_i    (bus.ready_i[v]),
                .req_port_o (req[v]),
                .valid_o    (valid[v]),
                .pop_o      (pop[v]),
                .idle_o     (idle[v])
            );
        end
    endgenerate

    // Empty FIFOs present an all-zero flit rather than stale storage.
    always_comb begin
        for (int v = 0; v < VN; v++) begin
            bus.data_o[v] = empty[v] ? '0 : head[v];
        end
        bus.ready_o     = in_ready_c;
        bus.valid_o     = valid;
        bus.req_port    = req;
        bus.count_o     = cnt;
        bus.cfg_ready_o = cfg_ready_c;
    end

endmodule

// File: tb/tb_cast_input_unit.sv
// Directed and random checks of cast_input_unit against a queue-based model.
module tb_cast_input_unit;
    import cast_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [VN-1:0][PN-1:0] RI = {5'b00000, 5'b00001, 5'b00010, 5'b00101};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cast_input_unit_if #(.DEPTH(DEPTH)) bus ();

    cast_input_unit #(.DEPTH(DEPTH), .ROUTE_INIT(RI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [VN-1:0] t_vc;
    flit_t         t_data;
    logic          t_valid;
    port_mask_t    t_rdy [VN];
    logic          t_cfg_we;
    vc_idx_t       t_cfg_vc;
    port_mask_t    t_cfg_mask;

    flit_t      mq      [VN][$];
    port_mask_t m_route [VN];
    port_mask_t m_pend  [VN];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic port_mask_t outstanding(input int v);
        return (m_pend[v] != '0) ? m_pend[v] : m_route[v];
    endfunction

    function automatic logic m_valid(input int v);
        return (mq[v].size() > 0) && (m_route[v] != '0);
    endfunction

    function automatic port_mask_t m_req(input int v);
        port_mask_t left = outstanding(v);
        if (!m_valid(v)) return '0;
`ifdef CAST_PARALLEL_FORK_EN
        return left;
`else
        for (int p = 0; p < PN; p++) if (left[p]) return port_mask_t'(1) << p;
        return '0;
`endif
    endfunction

    function automatic int sel_vc();
        if ($countones(t_vc) != 1) return -1;
        for (int v = 0; v < VN; v++) if (t_vc[v]) return v;
        return -1;
    endfunction

    function automatic logic m_ready();
        int s = sel_vc();
        return (s >= 0) && (mq[s].size() < DEPTH);
    endfunction

    function automatic logic m_cfg_ready();
        int c = int'(t_cfg_vc);
        if (c >= VN) return 1'b0;
        return (mq[c].size() == 0) && (m_pend[c] == '0);
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VN; v++) begin
            mq[v].delete();
            m_route[v] = RI[v];
            m_pend[v]  = '0;
        end
    endtask

    task automatic idle_inputs();
        t_vc = 4'b0001; t_data = '0; t_valid = 1'b0;
        t_cfg_we = 1'b0; t_cfg_vc = '0; t_cfg_mask = '0;
        for (int v = 0; v < VN; v++) t_rdy[v] = '0;
    endtask

    task automatic drive();
        bus.vc_i = t_vc; bus.data_i = t_data; bus.valid_i = t_valid;
        bus.cfg_we = t_cfg_we; bus.cfg_vc = t_cfg_vc; bus.cfg_mask = t_cfg_mask;
        for (int v = 0; v < VN; v++) bus.ready_i[v] = t_rdy[v];
    endtask

    task automatic compare_all();
        for (int v = 0; v < VN; v++) begin
            chk($sformatf("valid_o[%0d]", v), 64'(bus.valid_o[v]), 64'(m_valid(v)));
            chk($sformatf("req_port[%0d]", v), 64'(bus.req_port[v]), 64'(m_req(v)));
            chk($sformatf("count_o[%0d]", v), 64'(bus.count_o[v]), 64'(mq[v].size()));
            chk($sformatf("data_o[%0d]", v), 64'(bus.data_o[v]),
                (mq[v].size() > 0) ? 64'(mq[v][0]) : 64'(0));
        end
        chk("ready_o", 64'(bus.ready_o), 64'(m_ready()));
        chk("cfg_ready_o", 64'(bus.cfg_ready_o), 64'(m_cfg_ready()));
    endtask

    // Rules applied to the current state and inputs, as one clock edge.
    task automatic model_advance();
        int         s  = sel_vc();
        logic       wr = t_valid && m_ready();
        logic       cw = t_cfg_we && m_cfg_ready();
        port_mask_t left, req;
        logic       moved;
        for (int v = 0; v < VN; v++) begin
            if (mq[v].size() == 0) continue;
            if (m_route[v] == '0) begin
                void'(mq[v].pop_front());
                continue;
            end
`ifdef CAST_PARALLEL_FORK_EN
            left  = outstanding(v) & ~t_rdy[v];
            moved = 1'b1;
            req   = '0;
`else
            req   = m_req(v);
            moved = (req & t_rdy[v]) != '0;
            left  = outstanding(v) & ~req;
`endif
            if (moved) begin
                if (left == '0) begin
                    void'(mq[v].pop_front());
                    m_pend[v] = '0;
                end else begin
                    m_pend[v] = left;
                end
            end
        end
        if (wr) mq[s].push_back(t_data);
        if (cw) m_route[int'(t_cfg_vc)] = t_cfg_mask;
    endtask

    task automatic step();
        drive();
        #3;
        compare_all();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic probe_ready(input logic [VN-1:0] vc, input logic exp, input string tag);
        bus.vc_i = vc;
        #1;
        chk(tag, 64'(bus.ready_o), 64'(exp));
    endtask

    initial begin
        idle_inputs();
        do_reset();

        for (int v = 0; v < VN; v++) begin
            chk($sformatf("rst_count[%0d]", v), 64'(bus.count_o[v]), 64'(0));
            chk($sformatf("rst_valid[%0d]", v), 64'(bus.valid_o[v]), 64'(0));
            chk($sformatf("rst_req[%0d]", v), 64'(bus.req_port[v]), 64'(0));
        end
        chk("rst_cfg_ready", 64'(bus.cfg_ready_o), 64'(1));
        probe_ready(4'b0001, 1'b1, "rst_ready_vc0");
        probe_ready(4'b0000, 1'b0, "ready_vc_zero");
        probe_ready(4'b0101, 1'b0, "ready_vc_multi");

        // Multicast of one flit on VC0 to ports 0 and 2.
        t_vc = 4'b0001; t_data = 32'hA5; t_valid = 1'b1;
        step();
        t_valid = 1'b0;
        chk("mc_valid0", 64'(bus.valid_o[0]), 64'(1));
        chk("mc_data0", 64'(bus.data_o[0]), 64'(32'hA5));
`ifdef CAST_PARALLEL_FORK_EN
        chk("mc_req0_first", 64'(bus.req_port[0]), 64'(5'b00101));
        t_rdy[0] = 5'b11111;
        step();
`else
        chk("mc_req0_first", 64'(bus.req_port[0]), 64'(5'b00001));
        t_rdy[0] = 5'b11111;
        step();
        chk("mc_req0_second", 64'(bus.req_port[0]), 64'(5'b00100));
        chk("mc_count0_mid", 64'(bus.count_o[0]), 64'(1));
        step();
`endif
        chk("mc_count0_done", 64'(bus.count_o[0]), 64'(0));
        idle_inputs();

        // Fill VC1, confirm back-pressure is per-VC and survives a same-cycle pop.
        t_vc = 4'b0010; t_valid = 1'b1;
        repeat (4) begin
            t_data = flit_t'($urandom);
            step();
        end
        chk("full_count1", 64'(bus.count_o[1]), 64'(4));
        probe_ready(4'b0010, 1'b0, "full_ready_vc1");
        probe_ready(4'b0001, 1'b1, "full_ready_vc0");
        t_vc = 4'b0010; t_rdy[1] = 5'b00010;
        step();
        chk("pop_count1", 64'(bus.count_o[1]), 64'(3));
        probe_ready(4'b0010, 1'b1, "pop_ready_vc1");
        t_valid = 1'b0;
        repeat (3) step();
        chk("drain_count1", 64'(bus.count_o[1]), 64'(0));
        idle_inputs();

        // Config write blocked while VC2 is occupied, accepted once drained.
        t_vc = 4'b0100; t_data = 32'h1234_5678; t_valid = 1'b1;
        step();
        t_valid = 1'b0;
        t_cfg_we = 1'b1; t_cfg_vc = 2'd2; t_cfg_mask = 5'b00011;
        bus.cfg_vc = 2'd2;
        #1;
        chk("cfg_busy", 64'(bus.cfg_ready_o), 64'(0));
        step();
        t_cfg_we = 1'b0;
        chk("cfg_mask_kept", 64'(bus.req_port[2]), 64'(5'b00001));
        t_rdy[2] = 5'b11111;
        step();
        t_rdy[2] = '0;
        chk("cfg_drained", 64'(bus.count_o[2]), 64'(0));
        t_cfg_we = 1'b1;
        step();
        t_cfg_we = 1'b0; t_valid = 1'b1; t_data = 32'hCAFE;
        step();
        t_valid = 1'b0;
`ifdef CAST_PARALLEL_FORK_EN
        chk("cfg_new_req", 64'(bus.req_port[2]), 64'(5'b00011));
`else
        chk("cfg_new_req", 64'(bus.req_port[2]), 64'(5'b00001));
        t_rdy[2] = 5'b11111;
        step();
        chk("cfg_new_req2", 64'(bus.req_port[2]), 64'(5'b00010));
`endif
        t_rdy[2] = 5'b11111;
        step();
        chk("cfg_new_done", 64'(bus.count_o[2]), 64'(0));
        idle_inputs();

`ifdef CAST_PARALLEL_FORK_EN
        // Parallel fork with staggered port acceptance.
        t_cfg_we = 1'b1; t_cfg_vc = 2'd2; t_cfg_mask = 5'b10110;
        step();
        t_cfg_we = 1'b0; t_vc = 4'b0100; t_valid = 1'b1; t_data = 32'hBEEF;
        step();
        t_valid = 1'b0; t_rdy[2] = 5'b00110;
        chk("par_req_all", 64'(bus.req_port[2]), 64'(5'b10110));
        step();
        chk("par_req_left", 64'(bus.req_port[2]), 64'(5'b10000));
        chk("par_count_mid", 64'(bus.count_o[2]), 64'(1));
        t_rdy[2] = 5'b10000;
        step();
        chk("par_count_done", 64'(bus.count_o[2]), 64'(0));
        idle_inputs();
`endif

        // Zero route mask on VC3 discards flits without requesting.
        t_vc = 4'b1000; t_valid = 1'b1;
        repeat (3) begin
            t_data = flit_t'($urandom);
            step();
        end
        t_valid = 1'b0;
        chk("disc_count3", 64'(bus.count_o[3]), 64'(1));
        chk("disc_valid3", 64'(bus.valid_o[3]), 64'(0));
        chk("disc_req3", 64'(bus.req_port[3]), 64'(0));
        step();
        chk("disc_empty3", 64'(bus.count_o[3]), 64'(0));
        idle_inputs();

        // Reset with a half-delivered flit on VC0 and data queued on VC1.
        t_vc = 4'b0010; t_valid = 1'b1; t_data = 32'h11;
        step();
        t_vc = 4'b0001; t_data = 32'h22;
        step();
        t_valid = 1'b0; t_rdy[0] = 5'b00001;
        step();
`ifndef CAST_PARALLEL_FORK_EN
        chk("mid_req0", 64'(bus.req_port[0]), 64'(5'b00100));
`endif
        do_reset();
        for (int v = 0; v < VN; v++) begin
            chk($sformatf("mid_rst_count[%0d]", v), 64'(bus.count_o[v]), 64'(0));
            chk($sformatf("mid_rst_valid[%0d]", v), 64'(bus.valid_o[v]), 64'(0));
        end
        t_vc = 4'b0100; t_valid = 1'b1; t_data = 32'h33;
        step();
        t_valid = 1'b0;
        chk("mid_rst_mask2", 64'(bus.req_port[2]), 64'(5'b00001));
        t_rdy[2] = 5'b11111;
        step();
        chk("mid_rst_pop2", 64'(bus.count_o[2]), 64'(0));

        // Random traffic, config writes and occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 8) t_vc = 4'b0001 << (r % 4);
            else if (r == 8) t_vc = '0;
            else t_vc = 4'($urandom);
            t_valid    = ($urandom_range(0, 3) != 0);
            t_data     = flit_t'($urandom);
            for (int v = 0; v < VN; v++)
                t_rdy[v] = ($urandom_range(0, 9) < 3) ? '0 : port_mask_t'($urandom);
            t_cfg_we   = ($urandom_range(0, 15) == 0);
            t_cfg_vc   = vc_idx_t'($urandom);
            t_cfg_mask = ($urandom_range(0, 7) == 0) ? '0 : port_mask_t'($urandom);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cast_input_unit.md
# cast_input_unit

Parametrised multicast input port for the cast NoC router, successor to the fixed-depth, elaboration-time-configured input stage. Buffers incoming flits in per-VC FWFT FIFOs and drives one request per VC toward the crossbar. Each VC's destination port mask is a run-time-writable register. The head flit is replicated to every port in that mask, either serially or by parallel fork, and is popped only after all copies are delivered.

## Interface
- `VN`, 4: number of virtual channels.
- `PN`, 5: number of router output ports.
- `DW`, 32: flit width.
- `DEPTH`, 4: FIFO depth per VC; power of two, at least 2.
- `ROUTE_INIT`, all zero: reset value of each VC's port mask (`VN` entries of `PN` bits).
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous and active-high.
- `vc_i`  in  `VN`  one-hot VC select, qualified by `valid_i`.
- `data_i`  in  `DW`  input flit.
- `valid_i`  in  1  input valid.
- `ready_o`  out  1  input ready.
- `data_o[VN]`  out  `DW`  head flit per VC.
- `valid_o[VN]`  out  1  head flit pending per VC.
- `req_port[VN]`  out  `PN`  requested output port(s) per VC.
- `ready_i[VN]`  in  `PN`  per-port acceptance from the crossbar.
- `count_o[VN]`  out  `$clog2(DEPTH+1)`  FIFO occupancy per VC.
- `cfg_we`  in  1  routing-mask write strobe.
- `cfg_vc`  in  `$clog2(VN)`  target VC of the write.
- `cfg_mask`  in  `PN`  new port mask.
- `cfg_ready_o`  out  1  write may be accepted.

## Operation
- Input handshake:
  - `ready_o` is `~full` of the VC selected by `vc_i`.
  - `ready_o` is 0 if `vc_i` is zero or not one-hot; no write occurs in that case.
  - A write happens when `valid_i & ready_o`.
- Each VC has a `pending` register, reset 0. The effective mask is `eff = (pending==0) ? route_mask : pending`.
- `valid_o[v] = ~empty[v] & (route_mask[v] != 0)`.
- Serial mode (default):
  - `req_port` is the lowest set bit of `eff`.
  - A transfer completes when `valid_o & |(req_port & ready_i)`.
  - On completion `pending <= eff & ~req_port`.
- Pop rule: when the remaining mask would become 0, the FIFO pops and `pending <= 0`.
- A zero route mask with a non-empty FIFO discards one flit per cycle. During the discard `valid_o = 0` and `req_port = 0`.
- Config write:
  - Accepted when `cfg_we & cfg_ready_o`.
  - `cfg_ready_o = empty[cfg_vc] & (pending[cfg_vc]==0)`.
  - The new mask applies from the next cycle.
  - A write to an out-of-range `cfg_vc` is ignored, and `cfg_ready_o` is 0.
- `count_o` is incremented on write and decremented on pop. A simultaneous write and pop leaves it unchanged.

## Timing
- All outputs reset to 0, except that `ready_o` follows the input-handshake rule and `cfg_ready_o` is 1 for an in-range VC.
- Route masks reset to `ROUTE_INIT`.
- Write-to-`valid_o` latency is 1 cycle. There is no empty-FIFO bypass.
- Full FIFO: a write and a pop in the same cycle still see `ready_o = 0`, because `full` is registered state. There is no combinational path from `ready_i` to `ready_o`.
- `req_port` and `data_o` are stable while `valid_o` is high and no completion occurs.
- Serial multicast to k ports takes at least k cycles per flit.
- Reset mid-operation flushes all FIFOs and `pending` regardless of partially delivered copies.

## Configuration
- Macro `CAST_PARALLEL_FORK_EN`.
- When defined:
  - `req_port = eff`, i.e. all outstanding ports at once.
  - Each cycle `pending <= eff & ~(eff & ready_i)`.
  - The pop happens in the cycle when the remaining mask becomes 0, so delivery to all ports in one cycle is possible.
- When undefined: serial mode as described under Operation.
- Port list is identical in both builds.

## Structure
- Package `cast_pkg` holds:
  - constants `VN`, `PN`, `DW`;
  - typedefs `vc_idx_t` (`$clog2(VN)` bits), `port_mask_t` (`PN` bits), `flit_t` (`DW` bits).
- One sub-module, `cast_fork_tracker`, instantiated once per VC. It holds `route_mask` and `pending` and generates `req_port` and `pop`.
- FIFO storage reuses the existing `network_fifo` with `FWFT = 1` and the active-high reset tied to `rst`.

## Test plan
- Reset with `ROUTE_INIT[0] = 5'b00101`. Write flit `0xA5` on VC0 -> `valid_o[0] = 1` one cycle later and `req_port[0] = 00001`. With `ready_i = 11111`, the next cycle shows `req_port = 00100`. The pop follows and `count_o[0]` returns to 0.
- Fill VC1 with 4 flits while `ready_i = 0` -> `ready_o = 0` whenever `vc_i = 0010`, while VC0 still accepts. Pop one flit -> `ready_o` for VC1 rises the following cycle.
- Write cfg mask `00011` to VC2 while VC2 holds a flit -> `cfg_ready_o = 0` and the mask is unchanged. Retry after the drain -> the mask applies to the next flit.
- With `CAST_PARALLEL_FORK_EN`, mask `10110` and `ready_i` alternating `00110` then `10000` -> the pop occurs on the second cycle and each port sees exactly one transfer.
- Route mask 0 with 3 flits queued on VC3 -> `valid_o[3]` stays 0, `count_o[3]` falls 3, 2, 1, 0 over 3 cycles, and `req_port[3]` stays 0.
- Assert `rst` with a flit half-delivered (`pending = 00100`) -> the next cycle shows every FIFO empty, all `count_o` at 0 and the masks back at `ROUTE_INIT`.
